// File: rtl/gb_timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer (FF04-FF07) with one-cycle timer interrupt request.
// Define GB_TIMER_GLITCH_EN to let DIV/TAC writes cause TIMA increments via the tin edge detector.
module gb_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_en,
  input  logic       stop,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  input  logic       write,
  output logic [7:0] rdata,
  output logic       irq
);

  typedef enum logic [1:0] {StIdle, StOvf, StReload} state_e;

  state_e      r_state;
  logic [15:0] r_sys_cnt;
  logic [7:0]  r_tima;
  logic [7:0]  r_tma;
  logic [2:0]  r_tac;
  logic [1:0]  r_cd;
  logic        r_tin;
  logic        r_stop_q;
  logic        r_irq;

  logic        w_tick;
  logic        w_wr;
  logic        w_div_wr;
  logic        w_tima_wr;
  logic        w_tma_wr;
  logic        w_tac_wr;
  logic        w_stop_rise;
  logic [2:0]  w_tac_nxt;
  logic [15:0] w_cnt_nxt;
  logic        w_sel;
  logic        w_tin_nxt;
  logic        w_fall;
  logic        w_inc;
  logic        w_tin_upd;

  assign w_tick      = cpu_en & ~stop;
  assign w_wr        = cpu_en & write;
  assign w_div_wr    = w_wr & (addr == 2'd0);
  assign w_tima_wr   = w_wr & (addr == 2'd1);
  assign w_tma_wr    = w_wr & (addr == 2'd2);
  assign w_tac_wr    = w_wr & (addr == 2'd3);
  assign w_stop_rise = cpu_en & stop & ~r_stop_q;
  assign w_tac_nxt   = w_tac_wr ? wdata[2:0] : r_tac;

  always_comb begin
    w_cnt_nxt = r_sys_cnt;
    if (w_div_wr || w_stop_rise) begin
      w_cnt_nxt = 16'h0000;
    end else if (w_tick) begin
      w_cnt_nxt = r_sys_cnt + 16'd1;
    end
  end

  // tin is evaluated on the post-write counter and post-write TAC of this tick.
  always_comb begin
    w_sel = 1'b0;
    case (w_tac_nxt[1:0])
      2'd0:    w_sel = w_cnt_nxt[9];
      2'd1:    w_sel = w_cnt_nxt[3];
      2'd2:    w_sel = w_cnt_nxt[5];
      default: w_sel = w_cnt_nxt[7];
    endcase
  end

  assign w_tin_nxt = w_tac_nxt[2] & w_sel;
  assign w_fall    = r_tin & ~w_tin_nxt;
  assign w_tin_upd = w_tick | w_div_wr | w_tac_wr | w_stop_rise;

`ifdef GB_TIMER_GLITCH_EN
  assign w_inc = w_tick & w_fall;
`else
  assign w_inc = w_tick & w_fall & ~w_div_wr & ~w_tac_wr;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_sys_cnt <= 16'h0000;
      r_tima    <= 8'h00;
      r_tma     <= 8'h00;
      r_tac     <= 3'b000;
      r_cd      <= 2'd0;
      r_tin     <= 1'b0;
      r_stop_q  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      if (cpu_en) begin
        r_stop_q  <= stop;
        r_sys_cnt <= w_cnt_nxt;
        r_tac     <= w_tac_nxt;
        if (w_tin_upd) r_tin <= w_tin_nxt;
        if (w_tma_wr) r_tma <= wdata;
        case (r_state)
          StIdle: begin
            if (w_tima_wr) begin
              r_tima <= wdata;
            end else if (w_inc) begin
              if (r_tima == 8'hff) begin
                r_tima  <= 8'h00;
                r_cd    <= 2'd3;
                r_state <= StOvf;
              end else begin
                r_tima <= r_tima + 8'd1;
              end
            end
          end
          StOvf: begin
            // A TIMA write during the overflow window cancels the pending reload.
            if (w_tima_wr) begin
              r_tima  <= wdata;
              r_state <= StIdle;
            end else if (w_tick) begin
              if (r_cd == 2'd0) begin
                r_tima  <= w_tma_wr ? wdata : r_tma;
                r_irq   <= 1'b1;
                r_state <= StReload;
              end else begin
                r_cd <= r_cd - 2'd1;
              end
            end
          end
          StReload: begin
            if (w_tma_wr) r_tima <= wdata;
            if (w_tick) r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (addr)
      2'd0:    rdata = r_sys_cnt[15:8];
      2'd1:    rdata = r_tima;
      2'd2:    rdata = r_tma;
      default: rdata = {5'b11111, r_tac};
    endcase
  end

  assign irq = r_irq;

endmodule

// File: doc/gb_timer.md
# gb_timer

Game Boy DIV/TIMA/TMA/TAC timer unit (FF04–FF07), downstream of the clock controller. Advances only on `cpu_en` strobes, so it runs at double rate in fast mode, and freezes while `stop` is high. Raises a one-cycle timer interrupt request toward the interrupt controller (IF bit 2).

## Interface

Parameters:
- none

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  synchronous reset, active-low
- `cpu_en`  in  1  T-cycle advance strobe from the clock controller; all state changes only on cycles with `cpu_en`=1
- `stop`  in  1  CPU STOP state; high freezes the timer
- `addr`  in  2  register select: 0 DIV, 1 TIMA, 2 TMA, 3 TAC
- `wdata`  in  8  write data
- `write`  in  1  write strobe; effective only when `cpu_en`=1
- `rdata`  out  8  combinational read data for `addr`
- `irq`  out  1  timer interrupt request, one `clk`-cycle pulse

## Operation

- `sys_cnt[15:0]` increments by 1 (wraps FFFF→0000) on each tick, where tick = `cpu_en` & ~`stop`.
- Rising edge of `stop` clears `sys_cnt` to 0.
- DIV = `sys_cnt[15:8]`. Any DIV write clears `sys_cnt` to 0; the written value is discarded.
- TAC: bit 2 enables the timer; bits 1:0 select the tap: 00→`sys_cnt[9]`, 01→`[3]`, 10→`[5]`, 11→`[7]`.
- `tin` = TAC[2] & selected bit. A 1→0 transition of `tin` between consecutive ticks increments TIMA.
- Reads:
  - DIV: `sys_cnt[15:8]`
  - TIMA: TIMA value
  - TMA: TMA value
  - TAC: {5'b11111, TAC[2:0]}
- State machine, advanced only on ticks:
  - IDLE: on an increment with TIMA=FF, TIMA becomes 00 → OVF, with countdown = 3.
  - OVF: TIMA reads 00; increments are ignored. Countdown decrements each tick. On the tick where the countdown reaches 0: TIMA ← TMA, assert `irq` → RELOAD.
  - RELOAD: lasts one tick, then → IDLE.
- Boundary rules:
  - TIMA write in IDLE together with an increment on the same tick: the write wins.
  - TIMA write in OVF: TIMA ← `wdata`, reload and `irq` are cancelled → IDLE.
  - TIMA write in RELOAD: ignored.
  - TMA write in RELOAD: TMA and TIMA both take `wdata`.
  - TMA write on the reload tick: TIMA is loaded with the new `wdata`.
  - TAC write: takes effect for the `tin` computed on the same tick (see Configuration).
  - `stop` high: no ticks occur; state, countdown and registers hold; writes are still accepted.
  - `reset_n` low mid-overflow: the pending reload is abandoned, no `irq`.

## Timing

- Reset values: `sys_cnt`=0000, TIMA=00, TMA=00, TAC=000 (reads F8), state IDLE, `irq`=0. `rdata` follows `addr` combinationally.
- A register write is visible on `rdata` in the `clk` cycle after the write tick.
- Overflow latency: TIMA increments FF→00 on tick t; ticks t+1..t+3 stay in OVF; on tick t+4 TIMA=TMA, and `irq` is high for exactly the `clk` cycle following tick t+4.
- At the normal rate (`cpu_en` every cycle): TAC=05 gives one TIMA increment per 16 ticks; TAC=04 gives one per 1024 ticks.

## Configuration

- `GB_TIMER_GLITCH_EN` defined:
  - `tin` is edge-detected as a whole, including write effects.
  - A DIV write while the selected bit is 1 increments TIMA.
  - A TAC write that changes `tin` from 1 to 0 increments TIMA. This covers clearing the enable bit and switching to a tap whose bit is 0.
- Macro undefined:
  - Increments come only from natural 1→0 carries of the selected `sys_cnt` bit with TAC[2]=1.
  - DIV and TAC writes never cause an increment.
  - The edge detector is reloaded with the post-write `tin`.

## Test plan

- Reset, TAC=05, TIMA=00, `cpu_en` held high for 64 clk → TIMA=04, `irq` never asserted, DIV=00.
- TMA=A0, TIMA=FF, TAC=05, run until increment → TIMA reads 00 for 3 ticks, then A0 with a single `irq` pulse 4 ticks after the overflow.
- Same setup, write TIMA=33 on the 2nd OVF tick → TIMA=33, no reload, no `irq`.
- Same setup, write TMA=55 on the reload tick → TIMA=55, TMA=55, `irq` asserted once.
- `sys_cnt`=0008 (bit 3 set), TAC=05, write DIV → with `GB_TIMER_GLITCH_EN` defined: TIMA +1 and DIV=00; without it: TIMA unchanged.
- `stop` 0→1 with `sys_cnt`=1234, hold for 100 clk → DIV=00 throughout, TIMA frozen; `stop`=0 → counting resumes from 0000.
